spu_decode_stage: RTL



---
 rtl/spu_decode_stage.sv | 105 ++++++++++
 1 files changed

// File: rtl/spu_decode_stage.sv
// spu_decode_stage: registered SPU decode stage with RAW scoreboard and replicated immediates
// Ports: clk/reset (async active-low); in_* upstream valid/ready instruction with pc8, fmt, imm sign, writes_rt;
//        out_* downstream valid/ready decoded fields (rt/ra/rb/rc, imm, pc8, fmt, writes_rt, illegal);
//        wb_en/wb_reg retire a destination; flush drops the held entry; stall_cnt counts hazard cycles (saturating).
// Option: define SPU_DECODE_WB_BYPASS_EN to let a same-cycle writeback release the hazard immediately.
module spu_decode_stage #(
  parameter int DATA_W      = 128,
  parameter int WORD_W      = 32,
  parameter int REG_CNT     = 128,
  parameter int STALL_CNT_W = 16,
  localparam int AW         = $clog2(REG_CNT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [31:0]            in_pc8,
  input  logic [2:0]             in_fmt,
  input  logic                   in_imm_sign,
  input  logic                   in_writes_rt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc8,
  output logic [2:0]             out_fmt,
  output logic [AW-1:0]          out_rt,
  output logic [AW-1:0]          out_ra,
  output logic [AW-1:0]          out_rb,
  output logic [AW-1:0]          out_rc,
  output logic [DATA_W-1:0]      out_imm,
  output logic                   out_writes_rt,
  output logic                   out_illegal,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_reg,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic                   held_q, held_d, sign_q, sign_d, wrt_q, wrt_d;
  logic [31:0]            instr_q, instr_d, pc8_q, pc8_d;
  logic [2:0]             fmt_q, fmt_d;
  logic [REG_CNT-1:0]     busy_q, busy_d, eff_busy, wb_mask, set_mask;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic [WORD_W-1:0]      word;
  logic                   rrr, use_a, use_b, use_c, hazard, cap, issue;
  always_comb begin
    rrr           = fmt_q == 3'd1;
    use_a         = fmt_q <= 3'd3;
    use_b         = fmt_q <= 3'd1;
    use_c         = rrr;
    out_illegal   = fmt_q[2] & fmt_q[1];
    out_writes_rt = wrt_q & ~out_illegal;
    out_pc8       = pc8_q;
    out_fmt       = fmt_q;
    out_rt        = AW'(rrr ? instr_q[27:21] : instr_q[6:0]);
    out_ra        = AW'(instr_q[13:7]);
    out_rb        = AW'(instr_q[20:14]);
    out_rc        = rrr ? AW'(instr_q[6:0]) : '0;
    word = fmt_q == 3'd2 ? {{(WORD_W-7){sign_q & instr_q[20]}}, instr_q[20:14]} :
           fmt_q == 3'd3 ? {{(WORD_W-10){sign_q & instr_q[23]}}, instr_q[23:14]} :
           fmt_q == 3'd4 ? {{(WORD_W-16){sign_q & instr_q[22]}}, instr_q[22:7]} :
           fmt_q == 3'd5 ? {{(WORD_W-18){sign_q & instr_q[24]}}, instr_q[24:7]} : '0;
    out_imm  = {(DATA_W/WORD_W){word}};
    wb_mask  = {{(REG_CNT-1){1'b0}}, wb_en} << wb_reg;
`ifdef SPU_DECODE_WB_BYPASS_EN
    eff_busy = busy_q & ~wb_mask;
`else
    eff_busy = busy_q;
`endif
    hazard    = held_q & ((use_a & eff_busy[out_ra]) | (use_b & eff_busy[out_rb]) | (use_c & eff_busy[out_rc]));
    out_valid = held_q & ~hazard & ~flush;
    in_ready  = reset & ~flush & (~held_q | (out_valid & out_ready));
    cap       = in_valid & in_ready;
    issue     = out_valid & out_ready;
    set_mask  = {{(REG_CNT-1){1'b0}}, issue & out_writes_rt} << out_rt;
    busy_d    = (busy_q & ~wb_mask) | set_mask;
    held_d    = ~flush & (cap | (held_q & ~issue));
    instr_d   = cap ? in_instr : instr_q;
    pc8_d     = cap ? in_pc8 : pc8_q;
    fmt_d     = cap ? in_fmt : fmt_q;
    sign_d    = cap ? in_imm_sign : sign_q;
    wrt_d     = cap ? in_writes_rt : wrt_q;
    stall_d   = hazard & ~&stall_q ? stall_q + STALL_CNT_W'(1) : stall_q;
    stall_cnt = stall_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      held_q  <= 1'b0;
      instr_q <= '0;
      pc8_q   <= '0;
      fmt_q   <= '0;
      sign_q  <= 1'b0;
      wrt_q   <= 1'b0;
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      held_q  <= held_d;
      instr_q <= instr_d;
      pc8_q   <= pc8_d;
      fmt_q   <= fmt_d;
      sign_q  <= sign_d;
      wrt_q   <= wrt_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
endmodule
